// File: rtl/ysyx_22050243_mem_pkg.sv
// Shared types and constants for the latency-modelled fetch/data memory.
// FSM state encodings, default base address, bus widths.
package ysyx_22050243_mem_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [XLEN-1:0] DEF_BASE_ADDR =
    64'h0000_0000_8000_0000;

  typedef enum logic {
    F_IDLE,
    F_WAIT
  } fetch_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WR_WAIT,
    D_RD_WAIT
  } data_state_t;

  function automatic logic [XLEN-1:0] word_off(
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] base
  );
    return addr - base;
  endfunction

endpackage

// File: rtl/ysyx_22050243_mem_resp_sram.sv
// 64-bit word array: two async read ports, one sync byte-masked write.
// Contents are never reset.
module ysyx_22050243_sram_2r1w #(
  parameter int DEPTH_LOG2 = 16,
  parameter int WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wmask,
  input  logic [DEPTH_LOG2-1:0] raddr0,
  output logic [WIDTH-1:0]      rdata0,
  input  logic [DEPTH_LOG2-1:0] raddr1,
  output logic [WIDTH-1:0]      rdata1
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (wmask[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/ysyx_22050243_mem_resp.sv
// Fixed-latency fetch and data memory responder over a shared array.
// Define YSYX_22050243_MEM_BOUNDS_CHECK_EN to zero/drop out-of-range accesses.
module ysyx_22050243_mem_resp
  import ysyx_22050243_mem_pkg::*;
#(
  parameter int IMEM_DATA_WIDTH = 64,
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64,
  parameter int MEM_DEPTH_LOG2  = 16,
  parameter logic [XLEN-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_inst_addr_valid,
  input  logic [IMEM_DATA_WIDTH-1:0] i_inst_addr,
  output logic                       inst_valid_o,
  output logic [IBUS_DATA_WIDTH-1:0] inst_o,
  input  logic                       i_data_w_en,
  input  logic [DBUS_DATA_WIDTH-1:0] i_data_w,
  input  logic [MASK_W-1:0]          i_data_w_mask,
  input  logic [DBUS_DATA_WIDTH-1:0] i_data_addr,
  output logic                       data_w_ready_o,
  input  logic                       i_data_r_en,
  output logic                       data_r_valid_o,
  output logic [DBUS_DATA_WIDTH-1:0] data_r_o
);

  localparam int D = MEM_DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  fetch_state_t               f_state, f_next;
  logic [CNT_W-1:0]           f_cnt;
  logic [IMEM_DATA_WIDTH-1:0] f_addr;
  logic                       f_keep;

  data_state_t                d_state, d_next;
  logic [CNT_W-1:0]           d_cnt;
  logic [DBUS_DATA_WIDTH-1:0] d_addr;
  logic [XLEN-1:0]            d_wdata;
  logic [MASK_W-1:0]          d_mask;
  logic                       d_accept;

  logic [XLEN-1:0] f_off, d_off;
  logic [D-1:0]    f_idx, d_idx;
  logic            f_in, d_in;
  logic [XLEN-1:0] f_raw, d_raw;
  logic            wr_fire, rd_fire;

  // ---- fetch FSM ----
  assign f_keep = i_inst_addr_valid
               && (i_inst_addr == f_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state <= F_IDLE;
      f_cnt   <= '0;
      f_addr  <= '0;
    end else begin
      f_state <= f_next;
      if (f_state == F_IDLE && i_inst_addr_valid) begin
        f_addr <= i_inst_addr;
        f_cnt  <= CNT_LOAD;
      end else if (f_next == F_IDLE) begin
        f_cnt <= '0;
      end else begin
        f_cnt <= f_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    f_next = f_state;
    unique case (f_state)
      F_IDLE: if (i_inst_addr_valid) f_next = F_WAIT;
      F_WAIT: if (!f_keep || f_cnt == '0) f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = '0;
    if (!rst && f_state == F_WAIT && f_keep && f_cnt == '0) begin
      inst_valid_o = 1'b1;
      inst_o = f_addr[2] ? IBUS_DATA_WIDTH'(f_raw[63:32])
                         : IBUS_DATA_WIDTH'(f_raw[31:0]);
    end
  end

  // ---- data FSM ----
  assign d_accept = i_data_w_en || i_data_r_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      d_cnt   <= '0;
      d_addr  <= '0;
      d_wdata <= '0;
      d_mask  <= '0;
    end else begin
      d_state <= d_next;
      if (d_state == D_IDLE && d_accept) begin
        d_addr  <= i_data_addr;
        d_wdata <= XLEN'(i_data_w);
        d_mask  <= i_data_w_mask;
        d_cnt   <= CNT_LOAD;
      end else if (d_next == D_IDLE) begin
        d_cnt <= '0;
      end else begin
        d_cnt <= d_cnt - 1'b1;
      end
    end
  end

  // write wins a tie; a still-held read is taken on the next IDLE
  always_comb begin
    d_next = d_state;
    unique case (d_state)
      D_IDLE: begin
        priority case (1'b1)
          i_data_w_en: d_next = D_WR_WAIT;
          i_data_r_en: d_next = D_RD_WAIT;
          default:     d_next = D_IDLE;
        endcase
      end
      D_WR_WAIT, D_RD_WAIT: if (d_cnt == '0) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    wr_fire        = !rst && d_state == D_WR_WAIT && d_cnt == '0;
    rd_fire        = !rst && d_state == D_RD_WAIT && d_cnt == '0;
    data_w_ready_o = wr_fire;
    data_r_valid_o = rd_fire;
    data_r_o       = rd_fire ? DBUS_DATA_WIDTH'(d_raw) : '0;
  end

  // ---- address decode ----
  assign f_off = word_off(XLEN'(f_addr), BASE_ADDR);
  assign d_off = word_off(XLEN'(d_addr), BASE_ADDR);
  assign f_idx = f_off[D+2:3];
  assign d_idx = d_off[D+2:3];

  logic unused_ok;
`ifdef YSYX_22050243_MEM_BOUNDS_CHECK_EN
  assign f_in = ~|f_off[XLEN-1:D+3];
  assign d_in = ~|d_off[XLEN-1:D+3];
  assign unused_ok = ^{f_off[2:0], d_off[2:0]};
`else
  assign f_in = 1'b1;
  assign d_in = 1'b1;
  assign unused_ok = ^{f_off[2:0], d_off[2:0],
                       f_off[XLEN-1:D+3], d_off[XLEN-1:D+3]};
`endif

  logic [XLEN-1:0] rdata0, rdata1;

  assign f_raw = f_in ? rdata0 : '0;
  assign d_raw = d_in ? rdata1 : '0;

  ysyx_22050243_sram_2r1w #(
    .DEPTH_LOG2 (D),
    .WIDTH      (XLEN)
  ) u_sram (
    .clk    (clk),
    .we     (wr_fire && d_in),
    .waddr  (d_idx),
    .wdata  (d_wdata),
    .wmask  (d_mask),
    .raddr0 (f_idx),
    .rdata0 (rdata0),
    .raddr1 (d_idx),
    .rdata1 (rdata1)
  );

endmodule
